ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe_if.sv | 32 +++
 rtl/ctrl_pipe.sv | 112 +++++++++++
 tb/tb_ctrl_pipe.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Signal bundle around ctrl_pipe: decode-side inputs, stage controls and per-stage state/hazard outputs.
// valid_d qualifies the decode word; there is no backpressure, so stall/flush are the only flow controls.
interface ctrl_pipe_if #(
  parameter int CW = 13,
  parameter int NS = 3,
  parameter int AW = 5
) ();
  logic [CW-1:0]    ctl_d;
  logic             valid_d;
  logic [AW-1:0]    dst_d;
  logic [AW-1:0]    rs_d;
  logic [AW-1:0]    rt_d;
  logic [NS-1:0]    stall;
  logic [NS-1:0]    flush;
  logic [NS*CW-1:0] ctl_q;
  logic [NS-1:0]    valid_q;
  logic [NS*AW-1:0] dst_q;
  logic [NS-1:0]    rs_hit;
  logic [NS-1:0]    rt_hit;
  logic             load_use;
  logic             stall_err;

  modport master (
    output ctl_d, valid_d, dst_d, rs_d, rt_d, stall, flush,
    input  ctl_q, valid_q, dst_q, rs_hit, rt_hit, load_use, stall_err
  );

  modport slave (
    input  ctl_d, valid_d, dst_d, rs_d, rt_d, stall, flush,
    output ctl_q, valid_q, dst_q, rs_hit, rt_hit, load_use, stall_err
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-word pipeline for stages E/M/W with per-stage stall/flush, register-hazard
// detection against the decode sources, and a sticky flag for non-prefix stall vectors.
module ctrl_pipe #(
    parameter int CW     = 13,
    parameter int NS     = 3,
    parameter int AW     = 5,
    parameter int RW_BIT = 8,
    parameter int MR_BIT = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    ctl_d,
    input  logic             valid_d,
    input  logic [AW-1:0]    dst_d,
    input  logic [AW-1:0]    rs_d,
    input  logic [AW-1:0]    rt_d,
    input  logic [NS-1:0]    stall,
    input  logic [NS-1:0]    flush,
    output logic [NS*CW-1:0] ctl_q,
    output logic [NS-1:0]    valid_q,
    output logic [NS*AW-1:0] dst_q,
    output logic [NS-1:0]    rs_hit,
    output logic [NS-1:0]    rt_hit,
    output logic             load_use,
    output logic             stall_err
);

    logic [NS-1:0]    stg_valid_q, stg_valid_d;
    logic [NS*CW-1:0] stg_ctl_q, stg_ctl_d;
    logic [NS*AW-1:0] stg_dst_q, stg_dst_d;
    logic             err_q, err_d;
    logic             stall_illegal;

    // A legal stall vector is a run of ones from bit 0; any 0->1 step upward breaks that.
    always_comb begin
        stall_illegal = 1'b0;
        for (int i = 1; i < NS; i++) begin
            if (stall[i] && !stall[i-1]) begin
                stall_illegal = 1'b1;
            end
        end
        err_d = err_q | stall_illegal;
    end

    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_ctl_d   = stg_ctl_q;
        stg_dst_d   = stg_dst_q;

        if (flush[0]) begin
            stg_valid_d[0]     = 1'b0;
            stg_ctl_d[0 +: CW] = '0;
            stg_dst_d[0 +: AW] = '0;
        end else if (!stall[0]) begin
            // Invalid decode slots still advance, but carry an all-zero control word.
            stg_valid_d[0]     = valid_d;
            stg_ctl_d[0 +: CW] = valid_d ? ctl_d : '0;
            stg_dst_d[0 +: AW] = dst_d;
        end

        for (int i = 1; i < NS; i++) begin
            if (flush[i]) begin
                stg_valid_d[i]        = 1'b0;
                stg_ctl_d[i*CW +: CW] = '0;
                stg_dst_d[i*AW +: AW] = '0;
            end else if (!stall[i]) begin
                if (stall[i-1]) begin
                    stg_valid_d[i]        = 1'b0;
                    stg_ctl_d[i*CW +: CW] = '0;
                    stg_dst_d[i*AW +: AW] = '0;
                end else begin
                    stg_valid_d[i]        = stg_valid_q[i-1];
                    stg_ctl_d[i*CW +: CW] = stg_ctl_q[(i-1)*CW +: CW];
                    stg_dst_d[i*AW +: AW] = stg_dst_q[(i-1)*AW +: AW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= '0;
            stg_ctl_q   <= '0;
            stg_dst_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_ctl_q   <= stg_ctl_d;
            stg_dst_q   <= stg_dst_d;
            err_q       <= err_d;
        end
    end

    // Hazard logic reads only registered stage state and decode operands, never stall/flush.
    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int i = 0; i < NS; i++) begin
            rs_hit[i] = stg_valid_q[i] & stg_ctl_q[i*CW + RW_BIT] &
                        (|stg_dst_q[i*AW +: AW]) & (stg_dst_q[i*AW +: AW] == rs_d);
            rt_hit[i] = stg_valid_q[i] & stg_ctl_q[i*CW + RW_BIT] &
                        (|stg_dst_q[i*AW +: AW]) & (stg_dst_q[i*AW +: AW] == rt_d);
        end
    end

    assign load_use  = valid_d & stg_valid_q[0] & stg_ctl_q[MR_BIT] & (rs_hit[0] | rt_hit[0]);
    assign ctl_q     = stg_ctl_q;
    assign valid_q   = stg_valid_q;
    assign dst_q     = stg_dst_q;
    assign stall_err = err_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed plus randomized bench for ctrl_pipe, compared against an array-based stage model.
module tb_ctrl_pipe;
  localparam int CW = 13;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int RW_BIT = 8;
  localparam int MR_BIT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.CW(CW), .NS(NS), .AW(AW)) bus ();

  ctrl_pipe #(.CW(CW), .NS(NS), .AW(AW), .RW_BIT(RW_BIT), .MR_BIT(MR_BIT)) dut (
    .clk(clk), .rst(rst),
    .ctl_d(bus.ctl_d), .valid_d(bus.valid_d), .dst_d(bus.dst_d),
    .rs_d(bus.rs_d), .rt_d(bus.rt_d), .stall(bus.stall), .flush(bus.flush),
    .ctl_q(bus.ctl_q), .valid_q(bus.valid_q), .dst_q(bus.dst_q),
    .rs_hit(bus.rs_hit), .rt_hit(bus.rt_hit), .load_use(bus.load_use),
    .stall_err(bus.stall_err)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model: one entry per stage
  logic          m_valid[NS];
  logic [CW-1:0] m_ctl[NS];
  logic [AW-1:0] m_dst[NS];
  logic          m_err;
  logic [NS-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [CW-1:0] c, input logic [AW-1:0] d,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [NS-1:0] st, input logic [NS-1:0] fl);
    bus.valid_d = v;
    bus.ctl_d = c;
    bus.dst_d = d;
    bus.rs_d = rs;
    bus.rt_d = rt;
    bus.stall = st;
    bus.flush = fl;
  endtask

  task automatic model_edge();
    logic          nv[NS];
    logic [CW-1:0] nc[NS];
    logic [AW-1:0] nd[NS];
    for (int i = 0; i < NS; i++) begin
      if (rst || bus.flush[i] || (!bus.stall[i] && i > 0 && bus.stall[i-1])) begin
        nv[i] = 1'b0; nc[i] = '0; nd[i] = '0;
      end else if (bus.stall[i]) begin
        nv[i] = m_valid[i]; nc[i] = m_ctl[i]; nd[i] = m_dst[i];
      end else if (i == 0) begin
        nv[i] = bus.valid_d; nc[i] = bus.valid_d ? bus.ctl_d : '0; nd[i] = bus.dst_d;
      end else begin
        nv[i] = m_valid[i-1]; nc[i] = m_ctl[i-1]; nd[i] = m_dst[i-1];
      end
    end
    if (rst) m_err = 1'b0;
    else begin
      for (int i = 0; i < NS; i++)
        for (int j = 0; j < i; j++)
          if (bus.stall[i] && !bus.stall[j]) m_err = 1'b1;
    end
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = nv[i]; m_ctl[i] = nc[i]; m_dst[i] = nd[i];
    end
  endtask

  function automatic logic [NS-1:0] m_hits(input logic [AW-1:0] src);
    logic [NS-1:0] h;
    for (int i = 0; i < NS; i++)
      h[i] = m_valid[i] && m_ctl[i][RW_BIT] && (m_dst[i] != 0) && (m_dst[i] == src);
    return h;
  endfunction

  task automatic check_all(input string tag);
    logic [NS-1:0]    ev;
    logic [NS*CW-1:0] ec;
    logic [NS*AW-1:0] ed;
    logic [NS-1:0]    hs, ht;
    for (int i = 0; i < NS; i++) begin
      ev[i] = m_valid[i];
      ec[i*CW +: CW] = m_ctl[i];
      ed[i*AW +: AW] = m_dst[i];
    end
    hs = m_hits(bus.rs_d);
    ht = m_hits(bus.rt_d);
    chk({tag, ".valid_q"}, 64'(bus.valid_q), 64'(ev));
    chk({tag, ".ctl_q"}, 64'(bus.ctl_q), 64'(ec));
    chk({tag, ".dst_q"}, 64'(bus.dst_q), 64'(ed));
    chk({tag, ".rs_hit"}, 64'(bus.rs_hit), 64'(hs));
    chk({tag, ".rt_hit"}, 64'(bus.rt_hit), 64'(ht));
    chk({tag, ".load_use"}, 64'(bus.load_use),
        64'(bus.valid_d && m_valid[0] && m_ctl[0][MR_BIT] && (hs[0] || ht[0])));
    chk({tag, ".stall_err"}, 64'(bus.stall_err), 64'(m_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0; m_ctl[i] = '0; m_dst[i] = '0;
    end
    m_err = 1'b0;

    // reset
    set_in(1'b1, 13'h1FFF, 5'd9, 5'd9, 5'd9, 3'b010, 3'b101);
    rst = 1'b1;
    step("reset0");
    step("reset1");
    chk("rst_valid", 64'(bus.valid_q), 64'd0);
    chk("rst_ctl", 64'(bus.ctl_q), 64'd0);
    chk("rst_err", 64'(bus.stall_err), 64'd0);
    set_in(1'b0, '0, '0, '0, '0, '0, '0);
    #1;
    chk("rst_load_use", 64'(bus.load_use), 64'd0);
    rst = 1'b0;

    // flow of a single word through E/M/W
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    exp_q.push_back(3'b100); exp_q.push_back(3'b000);
    set_in(1'b1, 13'h1ABC, 5'd7, '0, '0, '0, '0);
    step("flow1");
    chk("flow1_ctl0", 64'(bus.ctl_q[0 +: CW]), 64'h1ABC);
    chk("flow1_dst0", 64'(bus.dst_q[0 +: AW]), 64'd7);
    chk("flow1_valid", 64'(bus.valid_q), 64'(exp_q.pop_front()));
    set_in(1'b0, '0, '0, '0, '0, '0, '0);
    step("flow2");
    chk("flow2_ctl1", 64'(bus.ctl_q[CW +: CW]), 64'h1ABC);
    chk("flow2_valid", 64'(bus.valid_q), 64'(exp_q.pop_front()));
    step("flow3");
    chk("flow3_ctl2", 64'(bus.ctl_q[2*CW +: CW]), 64'h1ABC);
    chk("flow3_valid", 64'(bus.valid_q), 64'(exp_q.pop_front()));
    step("flow4");
    chk("flow4_valid", 64'(bus.valid_q), 64'(exp_q.pop_front()));

    // stall stage 0 with A in stage 1 and B in stage 0
    set_in(1'b1, 13'h0111, 5'd3, '0, '0, '0, '0);
    step("stl_a");
    set_in(1'b1, 13'h0222, 5'd4, '0, '0, '0, '0);
    step("stl_b");
    chk("stl_b_valid", 64'(bus.valid_q), 64'b011);
    set_in(1'b0, '0, '0, '0, '0, 3'b001, '0);
    step("stl_e1");
    chk("stl_e1_valid", 64'(bus.valid_q), 64'b101);
    chk("stl_e1_ctl0", 64'(bus.ctl_q[0 +: CW]), 64'h0222);
    chk("stl_e1_ctl2", 64'(bus.ctl_q[2*CW +: CW]), 64'h0111);
    step("stl_e2");
    chk("stl_e2_valid", 64'(bus.valid_q), 64'b001);
    set_in(1'b0, '0, '0, '0, '0, '0, '0);
    step("stl_rel");
    chk("stl_rel_valid", 64'(bus.valid_q), 64'b010);
    chk("stl_rel_ctl1", 64'(bus.ctl_q[CW +: CW]), 64'h0222);

    // flush beats stall
    set_in(1'b1, 13'h0333, 5'd6, '0, '0, '0, '0);
    step("fl_load");
    set_in(1'b0, '0, '0, '0, '0, 3'b001, 3'b001);
    step("fl_both");
    chk("fl_both_valid0", 64'(bus.valid_q[0]), 64'd0);
    chk("fl_both_ctl0", 64'(bus.ctl_q[0 +: CW]), 64'd0);

    // hazards: stage-0 load writer
    set_in(1'b1, 13'h1100, 5'd5, '0, '0, '0, '0);
    step("hz_load");
    set_in(1'b1, '0, '0, 5'd5, '0, '0, '0);
    #1;
    check_all("hz_rs");
    chk("hz_rs_hit0", 64'(bus.rs_hit[0]), 64'd1);
    chk("hz_load_use", 64'(bus.load_use), 64'd1);
    // destination 0 never hits
    set_in(1'b1, 13'h1100, 5'd0, '0, '0, '0, '0);
    step("hz_z_load");
    set_in(1'b1, '0, '0, 5'd0, 5'd0, '0, '0);
    #1;
    check_all("hz_z");
    chk("hz_z_rs_hit", 64'(bus.rs_hit), 64'd0);
    chk("hz_z_load_use", 64'(bus.load_use), 64'd0);
    // stage-1 writer: hit but no load-use
    set_in(1'b1, 13'h1100, 5'd5, '0, '0, '0, '0);
    step("hz_m_load");
    set_in(1'b0, '0, '0, '0, '0, '0, '0);
    step("hz_m_adv");
    set_in(1'b1, '0, '0, '0, 5'd5, '0, '0);
    #1;
    check_all("hz_m");
    chk("hz_m_rt_hit1", 64'(bus.rt_hit[1]), 64'd1);
    chk("hz_m_load_use", 64'(bus.load_use), 64'd0);

    // illegal stall vector sets a sticky flag
    set_in(1'b0, '0, '0, '0, '0, 3'b010, '0);
    step("ill");
    chk("ill_err", 64'(bus.stall_err), 64'd1);
    set_in(1'b0, '0, '0, '0, '0, 3'b001, '0);
    step("ill_sticky1");
    set_in(1'b0, '0, '0, '0, '0, 3'b011, '0);
    step("ill_sticky2");
    chk("ill_sticky_err", 64'(bus.stall_err), 64'd1);
    rst = 1'b1;
    step("ill_rst");
    chk("ill_rst_err", 64'(bus.stall_err), 64'd0);
    chk("ill_rst_valid", 64'(bus.valid_q), 64'd0);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [NS-1:0] st, fl;
      int k;
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, NS);
        st = NS'((1 << k) - 1);
      end else begin
        st = NS'($urandom);
      end
      fl = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
      set_in(1'($urandom), CW'($urandom), AW'($urandom_range(0, 7)),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), st, fl);
      rst = ($urandom_range(0, 59) == 0);
      #1;
      check_all("rnd_in");
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
